// File: rtl/alu_pkg.sv
// Shared opcode/funct encodings and FSM state type for the execute-stage ALU.
// Mul/div encodings are only decoded when ALU_MULDIV_EN is defined.
package alu_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_LUI   = 2'b11;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Only instantiated when ALU_MULDIV_EN is defined.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_SETUP = 2'd1;
    localparam logic [1:0] PH_ITER  = 2'd2;
    localparam logic [1:0] PH_FIX   = 2'd3;

    logic [1:0]         phase;
    logic               div_q, sgn_q;
    logic [WIDTH-1:0]   a_q, b_q, mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, acc_mul, acc_div, prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum_m, rem_sh, trial;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   q_raw, r_raw, fix_hi, fix_lo;

    assign a_neg = sgn_q && a_q[WIDTH-1];
    assign b_neg = sgn_q && b_q[WIDTH-1];
    assign mag_a = a_neg ? -a_q : a_q;
    assign mag_b = b_neg ? -b_q : b_q;
    assign done  = (phase == PH_ITER) && (cnt == CW'(WIDTH - 1));

    assign sum_m   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign acc_mul = {sum_m, acc[WIDTH-1:1]};
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, mag_b};
    assign acc_div = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // Sign correction on magnitudes; the remainder follows the dividend's sign.
    assign prod  = (a_neg ^ b_neg) ? -acc : acc;
    assign q_raw = acc[WIDTH-1:0];
    assign r_raw = acc[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_q) begin
            if (b_q == '0) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_hi = a_neg ? -r_raw : r_raw;
                fix_lo = (a_neg ^ b_neg) ? -q_raw : q_raw;
            end
        end
    end

    assign res_lo = fix_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= PH_IDLE;
            div_q <= 1'b0;
            sgn_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        div_q <= op_div;
                        sgn_q <= op_signed;
                        phase <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    acc   <= {{WIDTH{1'b0}}, mag_a};
                    cnt   <= '0;
                    phase <= PH_ITER;
                end
                PH_ITER: begin
                    acc <= div_q ? acc_div : acc_mul;
                    cnt <= cnt + 1'b1;
                    if (done) phase <= PH_FIX;
                end
                default: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    phase <= PH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshake and result flags.
// Define ALU_MULDIV_EN to add MULT/MULTU/DIV/DIVU/MFHI/MFLO with HI/LO registers.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    state_t           state, state_next;
    logic             accept, load_md, md_done;
    logic [WIDTH-1:0] sum, diff, op_res, md_res;
    logic             add_ovf, sub_ovf, op_ovf, op_ill, op_muldiv, op_div, op_signed;

    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign sum      = data1 + data2;
    assign diff     = data1 - data2;
    assign add_ovf  = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
    assign sub_ovf  = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);

`ifdef ALU_MULDIV_EN
    logic [WIDTH-1:0] md_hi, md_lo;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && op_muldiv),
        .op_div    (op_div),
        .op_signed (op_signed),
        .a         (data1),
        .b         (data2),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo),
        .res_lo    (md_res)
    );
    assign load_md = (state == FIX);
`else
    assign md_done = 1'b0;
    assign md_res  = '0;
    assign load_md = 1'b0;
`endif

    always_comb begin
        op_res    = '0;
        op_ovf    = 1'b0;
        op_ill    = 1'b0;
        op_muldiv = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        case (alu_op)
            ALU_OP_ADD: op_res = sum;
            ALU_OP_SUB: op_res = diff;
            ALU_OP_LUI: op_res = data2 << (WIDTH / 2);
            default: begin
                case (funct)
                    FUNCT_ADD:  begin op_res = sum;  op_ovf = add_ovf; end
                    FUNCT_ADDU: op_res = sum;
                    FUNCT_SUB:  begin op_res = diff; op_ovf = sub_ovf; end
                    FUNCT_SUBU: op_res = diff;
                    FUNCT_AND:  op_res = data1 & data2;
                    FUNCT_OR:   op_res = data1 | data2;
                    FUNCT_XOR:  op_res = data1 ^ data2;
                    FUNCT_NOR:  op_res = ~(data1 | data2);
                    FUNCT_SLT:  op_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
                    FUNCT_SLTU: op_res = {{(WIDTH-1){1'b0}}, data1 < data2};
                    FUNCT_SLL:  op_res = data2 << shamt;
                    FUNCT_SRL:  op_res = data2 >> shamt;
                    FUNCT_SRA:  op_res = $unsigned($signed(data2) >>> shamt);
`ifdef ALU_MULDIV_EN
                    FUNCT_MULT:  begin op_muldiv = 1'b1; op_signed = 1'b1; end
                    FUNCT_MULTU: op_muldiv = 1'b1;
                    FUNCT_DIV:   begin op_muldiv = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
                    FUNCT_DIVU:  begin op_muldiv = 1'b1; op_div = 1'b1; end
                    FUNCT_MFHI:  op_res = md_hi;
                    FUNCT_MFLO:  op_res = md_lo;
`endif
                    default:    op_ill = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && op_muldiv) state_next = BUSY;
            BUSY:    if (md_done) state_next = FIX;
            default: state_next = IDLE;
        endcase
    end

    // A freshly loaded result wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && !op_muldiv) begin
                out_valid <= 1'b1;
                result    <= op_res;
                zero      <= (op_res == '0);
                overflow  <= op_ovf;
                illegal   <= op_ill;
            end else if (load_md) begin
                out_valid <= 1'b1;
                result    <= md_res;
                zero      <= (md_res == '0);
                overflow  <= 1'b0;
                illegal   <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; mul/div scenarios run only
// when ALU_MULDIV_EN is defined, otherwise those functs are checked as illegal.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data1, data2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero, overflow, illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .shamt     (shamt),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Offer one op, wait (bounded) for acceptance, return 1ns after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [SHW-1:0] sa,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        alu_op = op; funct = fn; shamt = sa; data1 = a; data2 = b; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        alu_op = 2'b00; funct = '0; shamt = '0; data1 = 32'd5; data2 = 32'd6;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", result); end
        checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero: got %0b want 0", zero); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b want 0", overflow); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %0b want 0", illegal); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_arith();
        issue(2'b10, 6'b100000, '0, 32'h7FFF_FFFF, 32'h1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %0b want 1", out_valid); end
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_result: got %h want 80000000", result); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL add_overflow: got %0b want 1", overflow); end
        issue(2'b10, 6'b100001, '0, 32'h7FFF_FFFF, 32'h1);
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("[TB] FAIL addu_result: got %h want 80000000", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL addu_overflow: got %0b want 0", overflow); end
        issue(2'b10, 6'b100010, '0, 32'h8000_0000, 32'h1);
        checks++; if (result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin errors++; $display("[TB] FAIL sub_ovf: got %h/%0b want 7fffffff/1", result, overflow); end
        issue(2'b10, 6'b100011, '0, 32'h8000_0000, 32'h1);
        checks++; if (result !== 32'h7FFF_FFFF || overflow !== 1'b0) begin errors++; $display("[TB] FAIL subu: got %h/%0b want 7fffffff/0", result, overflow); end
        issue(2'b01, 6'b111111, '0, 32'd2, 32'd2);
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("[TB] FAIL sub_zero: got %h/%0b want 0/1", result, zero); end
        checks++; if (overflow !== 1'b0 || illegal !== 1'b0) begin errors++; $display("[TB] FAIL sub_flags: got ovf %0b ill %0b want 0/0", overflow, illegal); end
        issue(2'b00, 6'b000000, '0, 32'h7FFF_FFFF, 32'h1);
        checks++; if (result !== 32'h8000_0000 || overflow !== 1'b0 || zero !== 1'b0) begin errors++; $display("[TB] FAIL aluop_add: got %h/%0b/%0b want 80000000/0/0", result, overflow, zero); end
        issue(2'b11, 6'b000000, '0, 32'h0, 32'h0000_1234);
        checks++; if (result !== 32'h1234_0000) begin errors++; $display("[TB] FAIL lui: got %h want 12340000", result); end
    endtask

    task automatic test_logic_shift();
        issue(2'b10, 6'b101010, '0, 32'hFFFF_FFFF, 32'd2);
        checks++; if (result !== 32'h1) begin errors++; $display("[TB] FAIL slt: got %h want 1", result); end
        issue(2'b10, 6'b101011, '0, 32'hFFFF_FFFF, 32'd2);
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("[TB] FAIL sltu: got %h/%0b want 0/1", result, zero); end
        issue(2'b10, 6'b000011, 5'd4, 32'h0, 32'h8000_0000);
        checks++; if (result !== 32'hF800_0000) begin errors++; $display("[TB] FAIL sra: got %h want f8000000", result); end
        issue(2'b10, 6'b000010, 5'd4, 32'h0, 32'h8000_0000);
        checks++; if (result !== 32'h0800_0000) begin errors++; $display("[TB] FAIL srl: got %h want 08000000", result); end
        issue(2'b10, 6'b000000, 5'd31, 32'h0, 32'h1);
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("[TB] FAIL sll: got %h want 80000000", result); end
        issue(2'b10, 6'b100100, '0, 32'hF0F0_0000, 32'hFF00_FF00);
        checks++; if (result !== 32'hF000_0000) begin errors++; $display("[TB] FAIL and: got %h want f0000000", result); end
        issue(2'b10, 6'b100101, '0, 32'hF0F0_0000, 32'hFF00_FF00);
        checks++; if (result !== 32'hFFF0_FF00) begin errors++; $display("[TB] FAIL or: got %h want fff0ff00", result); end
        issue(2'b10, 6'b100110, '0, 32'hF0F0_0000, 32'hFF00_FF00);
        checks++; if (result !== 32'h0FF0_FF00) begin errors++; $display("[TB] FAIL xor: got %h want 0ff0ff00", result); end
        issue(2'b10, 6'b100111, '0, 32'hF0F0_0000, 32'hFF00_FF00);
        checks++; if (result !== 32'h000F_00FF) begin errors++; $display("[TB] FAIL nor: got %h want 000f00ff", result); end
    endtask

    task automatic test_illegal();
        issue(2'b10, 6'b111111, '0, 32'h1234, 32'h5678);
        checks++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got valid %0b ill %0b want 1/1", out_valid, illegal); end
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("[TB] FAIL illegal_result: got %h/%0b want 0/1", result, zero); end
`ifndef ALU_MULDIV_EN
        issue(2'b10, 6'b011000, '0, 32'd3, 32'd5);
        checks++; if (illegal !== 1'b1 || result !== 32'h0) begin errors++; $display("[TB] FAIL mult_disabled: got ill %0b res %h want 1/0", illegal, result); end
        issue(2'b10, 6'b010000, '0, 32'd0, 32'd0);
        checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL mfhi_disabled: got ill %0b want 1", illegal); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stays_idle: in_ready %0b want 1", in_ready); end
`endif
    endtask

    task automatic test_backpressure();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        issue(2'b00, 6'b000000, '0, 32'd10, 32'd20);
        checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++; $display("[TB] FAIL bp_first: got %0b/%h want 1/1e", out_valid, result); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                alu_op = 2'b01; data1 = 32'd9; data2 = 32'd4; in_valid = 1'b1;
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready cyc %0d: got %0b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++; $display("[TB] FAIL bp_hold cyc %0d: got %0b/%h want 1/1e", i, out_valid, result); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin errors++; $display("[TB] FAIL bp_next: got %0b/%h want 1/5", out_valid, result); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_consumed: got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]       ops [3];
        logic [5:0]       fns [3];
        logic [WIDTH-1:0] a_v [3];
        logic [WIDTH-1:0] b_v [3];
        logic [WIDTH-1:0] exp_v [3];
        ops = '{2'b00, 2'b10, 2'b11};
        fns = '{6'b000000, 6'b100100, 6'b000000};
        a_v = '{32'd1, 32'h0000_00FF, 32'h0};
        b_v = '{32'd2, 32'h0000_000F, 32'h0000_ABCD};
        exp_v = '{32'd3, 32'h0000_000F, 32'hABCD_0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || result !== exp_v[i-1]) begin errors++; $display("[TB] FAIL b2b_%0d: got %0b/%h want 1/%h", i-1, out_valid, result, exp_v[i-1]); end
            end
            if (i < 3) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_%0d: got %0b want 1", i, in_ready); end
                alu_op = ops[i]; funct = fns[i]; data1 = a_v[i]; data2 = b_v[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv();
        int edges;
        issue(2'b10, 6'b011000, '0, 32'hFFFF_FFFD, 32'd5);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mult_busy_ready: got %0b want 0", in_ready); end
        edges = 0;
        while (out_valid !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++; if (edges != WIDTH + 2) begin errors++; $display("[TB] FAIL mult_latency: got %0d want %0d", edges, WIDTH + 2); end
        checks++; if (result !== 32'hFFFF_FFF1) begin errors++; $display("[TB] FAIL mult_result: got %h want fffffff1", result); end
        issue(2'b10, 6'b010000, '0, 32'h0, 32'h0);
        checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h want ffffffff", result); end
        issue(2'b10, 6'b010010, '0, 32'h0, 32'h0);
        checks++; if (result !== 32'hFFFF_FFF1) begin errors++; $display("[TB] FAIL mult_lo: got %h want fffffff1", result); end

        issue(2'b10, 6'b011010, '0, 32'hFFFF_FFF9, 32'd2);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 100) begin @(posedge clk); #1; edges++; end
        checks++; if (result !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_lo: got %h want fffffffd", result); end
        issue(2'b10, 6'b010000, '0, 32'h0, 32'h0);
        checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_hi: got %h want ffffffff", result); end

        issue(2'b10, 6'b011011, '0, 32'h0000_1234, 32'h0);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 100) begin @(posedge clk); #1; edges++; end
        checks++; if (result !== 32'hFFFF_FFFF || illegal !== 1'b0) begin errors++; $display("[TB] FAIL divz_lo: got %h ill %0b want ffffffff/0", result, illegal); end
        issue(2'b10, 6'b010000, '0, 32'h0, 32'h0);
        checks++; if (result !== 32'h0000_1234) begin errors++; $display("[TB] FAIL divz_hi: got %h want 00001234", result); end
    endtask

    task automatic test_reset_abort();
        int seen;
        issue(2'b10, 6'b011011, '0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %0b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_no_result: got %0d valid cycles want 0", seen); end
        issue(2'b10, 6'b010000, '0, 32'h0, 32'h0);
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("[TB] FAIL abort_hi: got %h want 0", result); end
        issue(2'b10, 6'b010010, '0, 32'h0, 32'h0);
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL abort_lo: got %h want 0", result); end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_logic_shift();
        test_illegal();
        test_backpressure();
        test_back_to_back();
`ifdef ALU_MULDIV_EN
        test_muldiv();
        test_reset_abort();
`endif
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, registered execute-stage ALU for the MIPS pipeline, successor to the combinational ALU-with-control. Decodes `alu_op`/`funct` exactly as the existing ALU control does. Adds:
- a valid/ready handshake and a registered result with overflow and illegal-op flags;
- shift operations;
- an optional iterative multiply/divide unit with HI/LO registers that stalls the pipeline while busy.

## Interface
Parameters:
- WIDTH, 32, datapath width (even, ≥ 8)
- SHW, $clog2(WIDTH), shift-amount width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- alu_op  in  2  00 add, 01 sub, 10 decode funct, 11 LUI
- funct  in  6  R-type function field
- shamt  in  SHW  shift amount for SLL/SRL/SRA
- data1  in  WIDTH  rs operand
- data2  in  WIDTH  rt / immediate operand
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream consumes when out_valid && out_ready
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow (ADD/SUB only)
- illegal  out  1  funct not decoded

## Operation
- alu_op 00: data1+data2, no overflow flag.
- alu_op 01: data1−data2, no overflow flag.
- alu_op 11: data2 << WIDTH/2.
- alu_op 10, funct decode:
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT (signed), 101011 SLTU
  - 000000 SLL, 000010 SRL, 000011 SRA, shifting data2 by shamt
- ADD/SUB set `overflow` on signed overflow. The result is still written (trap handled upstream).
- Undecoded funct: result 0, zero 1, illegal 1. The beat still completes.
- The unit uses a 3-state FSM:
  - IDLE: accepts when in_valid && in_ready. Single-cycle ops load the output register and stay in IDLE.
  - BUSY: mul/div iterating; in_ready = 0.
  - FIX: one cycle for sign correction, then the output register is loaded and the FSM returns to IDLE.
- in_ready = rst_n && state==IDLE && (!out_valid || out_ready), so back-to-back single-cycle ops run at full rate.
- out_valid clears on consume unless a new result loads in the same cycle.

## Timing
- Reset values: out_valid 0, result 0, zero 0, overflow 0, illegal 0, HI/LO 0, state IDLE. in_ready is 0 while rst_n is low.
- Single-cycle ops: accept at edge N, out_valid and result valid after edge N.
- Result is held stable while out_valid && !out_ready.
- Mul/div latency: WIDTH+2 edges from accept to out_valid (1 setup, WIDTH iterations, 1 FIX).
- Reset asserted mid-iteration aborts the operation. HI/LO return to 0 and no result is emitted.

## Configuration
- `ALU_MULDIV_EN` defined:
  - 011000 MULT, 011001 MULTU: shift-add, 2·WIDTH product into HI:LO.
  - 011010 DIV, 011011 DIVU: restoring division, LO = quotient, HI = remainder. Signed ops take magnitudes and fix signs in FIX. The remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = dividend, no illegal flag.
  - Completion beat: result = LO.
  - 010000 MFHI, 010010 MFLO: single-cycle reads of HI/LO.
- Undefined: those six functs are illegal, there are no HI/LO registers, and the FSM never leaves IDLE.

## Structure
- Package `alu_pkg`:
  - ALU_OP_* constants and FUNCT_* localparams
  - state enum {IDLE, BUSY, FIX}
- Sub-module `alu_muldiv_iter`: the iterative engine, instantiated only under `ALU_MULDIV_EN`. It has start/done, signed/op select, and HI/LO outputs.
- The combinational decode and single-cycle datapath stay in the top.

## Test plan
- alu_op 10, ADD, 0x7FFFFFFF + 1 → result 0x80000000, overflow 1; ADDU with the same operands → overflow 0.
- SLT −1 vs 2 → 1; SLTU 0xFFFFFFFF vs 2 → 0; SRA 0x80000000 by 4 → 0xF8000000; alu_op 01, 2−2 → zero 1.
- out_ready held 0 for 3 cycles after a result → in_ready 0, result stable; release → the next queued op completes on the following edge.
- Undecoded funct 111111 → illegal 1, result 0, out_valid 1 one cycle later.
- With `ALU_MULDIV_EN`:
  - MULT −3 × 5 → out_valid at WIDTH+2 edges, HI 0xFFFFFFFF, LO 0xFFFFFFF1.
  - DIV −7/2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF.
  - DIVU x/0 → LO 0xFFFFFFFF.
  - MFHI returns HI.
- rst_n low at iteration 10 of DIVU → no out_valid, HI/LO 0, in_ready 1 the cycle after release.
